// File: rtl/ps2_kbd_tx.sv
// ============================================================================
// ps2_kbd_tx -- PS/2 keyboard-side transmitter.
//
// Turns one key event (scancode + make/break flag) into the PS/2 byte
// sequence a keyboard would send and drives it on a generated PS/2 clock and
// data pair.
//   make  -> {code}
//   break -> {F0, code}
// With the optional macro PS2_TX_EXT_EN defined, req_ext=1 adds an E0 prefix:
//   make  -> {E0, code}
//   break -> {E0, F0, code}
// Without the macro req_ext is ignored.
//
// Each byte is an 11-bit frame: start 0, data LSB first, odd parity, stop 1.
// Each bit lasts 2*CLK_DIV clk cycles. ps2_clk is high for the first CLK_DIV
// cycles and low for the rest. ps2_data changes only at the start of the high
// phase. Bytes of one sequence are separated by GAP idle cycles.
//
// Parameters:
//   CLK_DIV  clk cycles per PS/2 clock half-period (2..255)
//   GAP      idle clk cycles between bytes of one sequence (1..255)
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  key event presented
//   req_ready  block can accept an event (IDLE only)
//   req_code   scancode
//   req_break  0 = make, 1 = break
//   req_ext    extended-key flag (used only with PS2_TX_EXT_EN)
//   ps2_clk    generated PS/2 clock
//   ps2_data   generated PS/2 data
//   busy       a sequence is in flight
//   done       one-cycle pulse when a sequence completes
// ============================================================================
module ps2_kbd_tx #(
    parameter int CLK_DIV = 4,
    parameter int GAP     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_code,
    input  logic       req_break,
    input  logic       req_ext,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // The byte counter only needs to reach the longest sequence length - 1.
`ifdef PS2_TX_EXT_EN
    localparam int BW = 2;
`else
    localparam int BW = 1;
`endif

    localparam logic [8:0] PH_LAST  = 9'(2 * CLK_DIV - 1);
    localparam logic [8:0] PH_HIGH  = 9'(CLK_DIV);
    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);
    localparam logic [7:0] BYTE_E0  = 8'hE0;
    localparam logic [7:0] BYTE_F0  = 8'hF0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [3:0]    bit_idx_q, bit_idx_d;     // 0 = start .. 10 = stop
    logic [8:0]    phase_q, phase_d;         // position inside one bit
    logic [7:0]    gap_cnt_q, gap_cnt_d;
    logic [BW-1:0] byte_idx_q, byte_idx_d;   // position inside the sequence
    logic [7:0]    code_q, code_d;
    logic          brk_q, brk_d;
`ifdef PS2_TX_EXT_EN
    logic          ext_q, ext_d;
`else
    logic          unused_ext;
    assign unused_ext = req_ext;
`endif
    logic          ps2_clk_q, ps2_clk_d;
    logic          ps2_data_q, ps2_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;

    // ------------------------------------------------------------------
    // Current byte of the sequence and index of the final byte
    // ------------------------------------------------------------------
    logic [7:0]    cur_byte;
    logic [BW-1:0] last_idx;

`ifdef PS2_TX_EXT_EN
    always_comb begin
        cur_byte = code_q;
        if (ext_q) begin
            if (byte_idx_q == 2'd0) begin
                cur_byte = BYTE_E0;
            end else if (brk_q && byte_idx_q == 2'd1) begin
                cur_byte = BYTE_F0;
            end
        end else if (brk_q && byte_idx_q == 2'd0) begin
            cur_byte = BYTE_F0;
        end
    end

    assign last_idx = {1'b0, brk_q} + {1'b0, ext_q};
`else
    always_comb begin
        cur_byte = code_q;
        if (brk_q && byte_idx_q == 1'b0) begin
            cur_byte = BYTE_F0;
        end
    end

    assign last_idx = brk_q;
`endif

    // Line value of frame bit idx for data byte b.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
        logic [3:0] k;
        k = idx - 4'd1;
        if (idx == 4'd0) begin
            frame_bit = 1'b0;               // start
        end else if (idx <= 4'd8) begin
            frame_bit = b[k[2:0]];          // data, LSB first
        end else if (idx == 4'd9) begin
            frame_bit = ~^b;                // odd parity
        end else begin
            frame_bit = 1'b1;               // stop
        end
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic. Outputs are computed here for the *next* cycle so
    // they come straight out of flops.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        phase_d    = phase_q;
        gap_cnt_d  = gap_cnt_q;
        byte_idx_d = byte_idx_q;
        code_d     = code_q;
        brk_d      = brk_q;
`ifdef PS2_TX_EXT_EN
        ext_d      = ext_q;
`endif
        ps2_clk_d  = ps2_clk_q;
        ps2_data_d = ps2_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ready_d    = ready_q;

        unique case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (req_valid && ready_q) begin
                    code_d     = req_code;
                    brk_d      = req_break;
`ifdef PS2_TX_EXT_EN
                    ext_d      = req_ext;
`endif
                    byte_idx_d = '0;
                    bit_idx_d  = 4'd0;
                    phase_d    = 9'd0;
                    state_d    = ST_SEND;
                    ps2_clk_d  = 1'b1;
                    ps2_data_d = 1'b0;       // start bit visible immediately
                    busy_d     = 1'b1;
                    ready_d    = 1'b0;
                end
            end

            ST_SEND: begin
                if (phase_q == PH_LAST) begin
                    // End of a bit: next cycle is the high phase of
                    // whatever comes next.
                    phase_d   = 9'd0;
                    ps2_clk_d = 1'b1;
                    bit_idx_d = 4'd0;
                    if (bit_idx_q == 4'd10) begin
                        ps2_data_d = 1'b1;
                        if (byte_idx_q == last_idx) begin
                            state_d    = ST_IDLE;
                            byte_idx_d = '0;
                            done_d     = 1'b1;
                            busy_d     = 1'b0;
                            ready_d    = 1'b1;
                        end else begin
                            state_d    = ST_GAP;
                            gap_cnt_d  = 8'd0;
                            byte_idx_d = byte_idx_q + BW'(1);
                        end
                    end else begin
                        bit_idx_d  = bit_idx_q + 4'd1;
                        ps2_data_d = frame_bit(cur_byte, bit_idx_q + 4'd1);
                    end
                end else begin
                    phase_d   = phase_q + 9'd1;
                    ps2_clk_d = ((phase_q + 9'd1) < PH_HIGH);
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d  = 8'd0;
                    state_d    = ST_SEND;
                    bit_idx_d  = 4'd0;
                    phase_d    = 9'd0;
                    ps2_clk_d  = 1'b1;
                    ps2_data_d = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                ps2_clk_d  = 1'b1;
                ps2_data_d = 1'b1;
                busy_d     = 1'b0;
                ready_d    = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_idx_q  <= 4'd0;
            phase_q    <= 9'd0;
            gap_cnt_q  <= 8'd0;
            byte_idx_q <= '0;
            code_q     <= 8'd0;
            brk_q      <= 1'b0;
`ifdef PS2_TX_EXT_EN
            ext_q      <= 1'b0;
`endif
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            phase_q    <= phase_d;
            gap_cnt_q  <= gap_cnt_d;
            byte_idx_q <= byte_idx_d;
            code_q     <= code_d;
            brk_q      <= brk_d;
`ifdef PS2_TX_EXT_EN
            ext_q      <= ext_d;
`endif
            ps2_clk_q  <= ps2_clk_d;
            ps2_data_q <= ps2_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    assign req_ready = ready_q;
    assign ps2_clk   = ps2_clk_q;
    assign ps2_data  = ps2_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// ============================================================================
// tb_ps2_kbd_tx -- directed bench for ps2_kbd_tx.
// Two instances share the stimulus: CLK_DIV=4/GAP=8 and CLK_DIV=2/GAP=8.
// sel chooses which instance the checks observe.
// ============================================================================
module tb_ps2_kbd_tx;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req_valid;
    logic [7:0] req_code;
    logic       req_break;
    logic       req_ext;

    logic rdy1, pclk1, pdat1, busy1, done1;
    logic rdy2, pclk2, pdat2, busy2, done2;

    ps2_kbd_tx #(.CLK_DIV(4), .GAP(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(rdy1),
        .req_code(req_code), .req_break(req_break), .req_ext(req_ext),
        .ps2_clk(pclk1), .ps2_data(pdat1), .busy(busy1), .done(done1)
    );

    ps2_kbd_tx #(.CLK_DIV(2), .GAP(8)) dut_div2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(rdy2),
        .req_code(req_code), .req_break(req_break), .req_ext(req_ext),
        .ps2_clk(pclk2), .ps2_data(pdat2), .busy(busy2), .done(done2)
    );

    logic sel;
    logic m_ready, m_clk, m_data, m_busy, m_done;
    assign m_ready = sel ? rdy2  : rdy1;
    assign m_clk   = sel ? pclk2 : pclk1;
    assign m_data  = sel ? pdat2 : pdat1;
    assign m_busy  = sel ? busy2 : busy1;
    assign m_done  = sel ? done2 : done1;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one event at a negedge, follow it to done. Returns cycles from
    // accept edge to the done cycle, the data bits sampled at each ps2_clk
    // falling edge, their count, and the cycle of the first falling edge.
    // After the accept edge the inputs switch to nxt_* with req_valid=hold.
    task automatic run_seq(input logic [7:0] code, input logic brk, input logic ext,
                           input logic hold, input logic [7:0] nxt_code, input logic nxt_brk,
                           output int cyc, output logic [32:0] bits,
                           output int nb, output int first_fall);
        int  c;
        logic prev;
        logic busy_drop;
        req_code  = code;
        req_break = brk;
        req_ext   = ext;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = hold;
        req_code  = nxt_code;
        req_break = nxt_brk;
        req_ext   = hold ? 1'b0 : ~ext;
        check("first_busy",  m_busy,  1);
        check("first_ready", m_ready, 0);
        check("first_data",  m_data,  0);
        check("first_clk",   m_clk,   1);
        c = 0; prev = 1'b1; busy_drop = 1'b0;
        bits = '0; nb = 0; first_fall = -1;
        while (!m_done && c < 2000) begin
            if (!m_busy) busy_drop = 1'b1;
            if (prev && !m_clk) begin
                if (nb < 33) bits[nb] = m_data;
                if (nb == 0) first_fall = c;
                nb++;
            end
            prev = m_clk;
            @(negedge clk);
            c++;
        end
        cyc = c;
        check("done_seen",  m_done, 1);
        check("busy_held",  busy_drop, 0);
        check("done_busy",  m_busy, 0);
        check("done_ready", m_ready, 1);
        check("done_clk",   m_clk, 1);
        check("done_data",  m_data, 1);
        $display("seq code=%02h brk=%0d ext=%0d cycles=%0d falls=%0d bits=%09h",
                 code, brk, ext, cyc, nb, bits);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int          cyc, nb, ff, dcount;
    logic [32:0] bits;

    initial begin
        sel       = 1'b0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_code  = 8'h00;
        req_break = 1'b0;
        req_ext   = 1'b0;

        // Reset state with no clock edge yet
        #2;
        check("rst_ready", m_ready, 1);
        check("rst_clk",   m_clk,   1);
        check("rst_data",  m_data,  1);
        check("rst_busy",  m_busy,  0);
        check("rst_done",  m_done,  0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", m_ready, 1);

        // Make 0x1C
        run_seq(8'h1C, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b1, cyc, bits, nb, ff);
        check("mk1c_cycles", cyc, 88);
        check("mk1c_bits",   bits[10:0], 11'h438);
        check("mk1c_falls",  nb, 11);
        check("mk1c_ffall",  ff, 4);
        @(negedge clk);
        check("mk1c_done_1cyc", m_done, 0);
        check("mk1c_idle_rdy",  m_ready, 1);

        // Break 0x1C
        run_seq(8'h1C, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0, cyc, bits, nb, ff);
        check("bk1c_cycles", cyc, 184);
        check("bk1c_bits",   bits[21:0], {11'h438, 11'h7E0});
        check("bk1c_falls",  nb, 22);
        @(negedge clk);

        // Back-to-back with req_valid held high
        run_seq(8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b1, cyc, bits, nb, ff);
        check("b2b_first_cycles", cyc, 88);
        check("b2b_first_bits",   bits[10:0], 11'h438);
        run_seq(8'h1C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, cyc, bits, nb, ff);
        check("b2b_second_cycles", cyc, 184);
        check("b2b_second_bits",   bits[21:0], {11'h438, 11'h7E0});
        @(negedge clk);

        // Reset during bit 5 (low phase) of a make frame
        req_code  = 8'h1C;
        req_break = 1'b0;
        req_ext   = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (45) @(negedge clk);
        check("mid_clk_low", m_clk,  0);
        check("mid_busy",    m_busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_clk",   m_clk,   1);
        check("arst_data",  m_data,  1);
        check("arst_busy",  m_busy,  0);
        check("arst_ready", m_ready, 1);
        check("arst_done",  m_done,  0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_done) dcount++;
        end
        check("arst_no_done", dcount, 0);
        check("arst_idle",    m_ready, 1);

        // Fresh make 0x32 after reset
        run_seq(8'h32, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, cyc, bits, nb, ff);
        check("mk32_cycles", cyc, 88);
        check("mk32_bits",   bits[10:0], 11'h464);
        @(negedge clk);

        // Break 0x75 with req_ext=1
        run_seq(8'h75, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, cyc, bits, nb, ff);
`ifdef PS2_TX_EXT_EN
        check("ext75_cycles", cyc, 280);
        check("ext75_bits",   bits, {11'h4EA, 11'h7E0, 11'h5C0});
        check("ext75_falls",  nb, 33);
`else
        check("ext75_cycles", cyc, 184);
        check("ext75_bits",   bits, {11'h000, 11'h4EA, 11'h7E0});
        check("ext75_falls",  nb, 22);
`endif
        @(negedge clk);

        // CLK_DIV=2 instance, make 0xFF
        sel = 1'b1;
        #0;
        check("div2_idle", m_ready, 1);
        run_seq(8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, cyc, bits, nb, ff);
        check("div2_cycles", cyc, 44);
        check("div2_bits",   bits[10:0], 11'h7FE);
        check("div2_ffall",  ff, 2);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_tx.md
PS2_KBD_TX -- requirements
Module: ps2_kbd_tx

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per PS/2 clock half-period; legal range 2..255.
REQ-002 Parameter GAP, default 8: idle clk cycles between consecutive bytes of one scancode sequence; legal range 1..255.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  a key event is presented.
REQ-006 req_ready  output  1  block can accept a key event.
REQ-007 req_code  input  8  scancode of the key.
REQ-008 req_break  input  1  0 = make (key press), 1 = break (key release).
REQ-009 req_ext  input  1  extended-key flag; used only under PS2_TX_EXT_EN.
REQ-010 ps2_clk  output  1  generated PS/2 clock line.
REQ-011 ps2_data  output  1  generated PS/2 data line.
REQ-012 busy  output  1  a sequence is being transmitted.
REQ-013 done  output  1  one-cycle pulse when a sequence completes.

Function
REQ-014 Handshake: req_ready=1 only in state IDLE; accept when req_valid&&req_ready at a rising edge; req_code/req_break/req_ext captured on that edge; later input changes ignored until the next accept.
REQ-015 States: IDLE, SEND (bit index 0..10), GAP; byte-sequence counter selects the current byte.
REQ-016 Sequence: make = {code}; break = {F0, code}.
REQ-017 Frame: 11 bits -- start 0, 8 data bits LSB first, odd parity (total of data+parity ones is odd), stop 1.
REQ-018 Bit timing: each bit lasts 2*CLK_DIV cycles; ps2_clk=1 for the first CLK_DIV cycles, then 0 for CLK_DIV cycles; ps2_data changes only at the start of the high phase.
REQ-019 Latency: on the cycle after the accept edge, busy=1, req_ready=0, ps2_data=0 (start bit), ps2_clk=1.
REQ-020 Between bytes of one sequence: state GAP for exactly GAP cycles with ps2_clk=1 and ps2_data=1.
REQ-021 After the low phase of the last stop bit: done=1 for exactly one cycle, busy=0, req_ready=1, state IDLE in that same cycle.
REQ-022 IDLE outputs: ps2_clk=1, ps2_data=1, busy=0, done=0.
REQ-023 req_valid asserted while busy is held off (no accept, no loss); it is accepted on the first cycle req_ready=1.
REQ-024 Back-to-back: an accept in the done cycle starts the next start bit on the following cycle.
REQ-025 Total cycles from accept to done = N_bytes*22*CLK_DIV + (N_bytes-1)*GAP.

Reset
REQ-026 rst=1 forces immediately, without clk: state IDLE, counters 0, ps2_clk=1, ps2_data=1, busy=0, done=0, req_ready=1.
REQ-027 Reset during a frame abandons it; no done pulse; after rst release the block is IDLE and accepts on the next valid edge.

Configuration
REQ-028 Macro PS2_TX_EXT_EN defined: req_ext=1 prefixes E0 -> make = {E0, code}, break = {E0, F0, code}; req_ext=0 behaves as undefined.
REQ-029 PS2_TX_EXT_EN undefined: req_ext ignored; sequences per REQ-016 only; byte counter sized for 2 bytes.

Verification (CLK_DIV=4, GAP=8 unless stated)
REQ-030 Make 0x1C -> ps2_data bits 0,0,0,1,1,1,0,0,0,0,1 (start,LSB..MSB,parity=0,stop); 11 ps2_clk falling edges; done 88 cycles after accept.
REQ-031 Break 0x1C -> frame F0 (parity 1), 8 idle cycles, frame 1C; done 184 cycles after accept; busy continuously 1 until done.
REQ-032 req_valid held high across two events (make 0x1C, then break 0x1C) -> second accepted in the done cycle of the first; no gap beyond 1 cycle.
REQ-033 rst pulsed at bit 5 of a make frame -> ps2_clk=1, ps2_data=1 asynchronously; no done; fresh make 0x32 afterwards transmits correctly.
REQ-034 With PS2_TX_EXT_EN: break 0x75 with req_ext=1 -> frames E0, F0, 75 with 8-cycle gaps; done 280 cycles after accept; without the macro, same stimulus -> F0, 75 only, done at 184.
REQ-035 CLK_DIV=2, make 0xFF -> parity bit 1, each bit 4 cycles, done 44 cycles after accept.
